// File: rtl/f51m_vector_sequencer.sv
// f51m_vector_sequencer: drives the f51m core from a stream or a 0..255 sweep, captures results into a FIFO.
// Optional MISR signature over captured results when F51M_SEQ_MISR_EN is defined.
module f51m_vector_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        sweep_start,
  output logic [7:0]  core_in,
  input  logic [7:0]  core_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        sweep_done,
  output logic [7:0]  signature
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, PUSH = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic sweep, full, pop, wr, start, acc;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign wr = state == PUSH && (!full || pop);
  assign in_ready = rst_n && state == IDLE;
  assign start = state == IDLE && sweep_start;
  assign acc = state == IDLE && !sweep_start && in_valid;
  assign out_data = out_valid ? mem[rptr] : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sweep <= 1'b0;
      core_in <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= wr && sweep && core_in == 8'hFF;
      case (state)
        IDLE: if (start || acc) begin
          core_in <= start ? 8'h00 : in_data;
          sweep <= start;
          cnt <= 4'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt == '0 ? cnt : cnt - 4'd1;
          state <= cnt == '0 ? PUSH : SETTLE;
        end
        PUSH: if (wr) begin
          if (sweep && core_in != 8'hFF) begin
            core_in <= core_in + 8'd1;
            cnt <= 4'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end else begin
            sweep <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wr ? wptr + AW'(1) : wptr;
      rptr <= pop ? rptr + AW'(1) : rptr;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= {core_in, core_out};
`ifdef F51M_SEQ_MISR_EN
  logic [7:0] sig;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= '0;
    else if (start) sig <= '0;
    else if (wr) sig <= {sig[6:0], sig[7] ^ sig[5] ^ sig[4] ^ sig[3]} ^ core_out;
  assign signature = sig;
`else
  assign signature = 8'h00;
`endif
endmodule

// File: tb/tb_f51m_vector_sequencer.sv
// tb_f51m_vector_sequencer: table vectors, corner sequences and a randomized scoreboard run for the sequencer.
module tb_f51m_vector_sequencer;
  logic clk = 0, rst_n = 0, in_valid = 0, sweep_start = 0, out_ready = 0;
  logic in_ready, out_valid, busy, sweep_done;
  logic [7:0] in_data = 0, core_in, core_out, signature, sig_a, sig_b;
  logic [15:0] out_data;
  int tests = 0, fails = 0;
  logic [15:0] q[$];
  typedef struct { logic [7:0] vin; logic [15:0] exp; } vec_t;
  vec_t tbl[5];
  always #5 clk = ~clk;
  function automatic logic [7:0] core_fn(input logic [7:0] v);
    return {~v[7], v[6] ^ v[7], v[7] & ~v[6], v[4:0] ^ {v[3:0], 1'b0}};
  endfunction
  assign core_out = core_fn(core_in);
  f51m_vector_sequencer #(.SETTLE_CYCLES(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sweep_start(sweep_start), .core_in(core_in), .core_out(core_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .sweep_done(sweep_done),
    .signature(signature));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] v);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick;
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    in_valid = 1;
    in_data = v;
    tick;
    in_valid = 0;
  endtask
  task automatic run_sweep(output logic [7:0] sig);
    int n = 0, dn = 0, cyc = 0;
    logic [7:0] gold = 0, r;
    while (!in_ready && cyc < 100) begin
      tick;
      cyc++;
    end
    out_ready = 1;
    in_valid = 1;
    in_data = 8'h55;
    sweep_start = 1;
    tick;
    sweep_start = 0;
    in_valid = 0;
    chk("sweep_sig_clear", 32'(signature), 32'd0);
    chk("sweep_core_in0", 32'(core_in), 32'd0);
    cyc = 0;
    while ((n < 256 || busy) && cyc < 2000) begin
      if (out_valid) begin
        r = out_data[7:0];
        chk("sweep_entry", 32'(out_data), 32'({n[7:0], core_fn(n[7:0])}));
        chk("sweep_prop", 32'({r[7], r[6]}), 32'({~out_data[15], out_data[14] ^ out_data[15]}));
        gold = {gold[6:0], gold[7] ^ gold[5] ^ gold[4] ^ gold[3]} ^ r;
        n++;
      end
      if (sweep_done) dn++;
      tick;
      cyc++;
    end
    chk("sweep_count", 32'(n), 32'd256);
    chk("sweep_done_pulses", 32'(dn), 32'd1);
    tick;
    chk("sweep_no_extra", 32'(out_valid), 32'd0);
    chk("sweep_done_low", 32'(sweep_done), 32'd0);
`ifdef F51M_SEQ_MISR_EN
    chk("sweep_signature", 32'(signature), 32'(gold));
`else
    chk("sweep_signature", 32'(signature), 32'd0);
`endif
    sig = signature;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'h00, 16'h0080};
    tbl[1] = '{8'h80, 16'h8060};
    tbl[2] = '{8'hC0, 16'hC000};
    tbl[3] = '{8'h5A, 16'h5ACE};
    tbl[4] = '{8'hFF, 16'hFF01};
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_core_in", 32'(core_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    chk("rst_signature", 32'(signature), 32'd0);
    rst_n = 1;
    tick;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1;
    foreach (tbl[i]) begin
      send(tbl[i].vin);
      chk("vec_busy", 32'(busy), 32'd1);
      chk("vec_lat0", 32'(out_valid), 32'd0);
      tick;
      chk("vec_lat1", 32'(out_valid), 32'd0);
      tick;
      chk("vec_lat2", 32'(out_valid), 32'd1);
      chk("vec_data", 32'(out_data), 32'(tbl[i].exp));
      tick;
      chk("vec_popped", 32'(out_valid), 32'd0);
    end
    out_ready = 0;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    repeat (4) tick;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_core_in", 32'(core_in), 32'h14);
    chk("bp_head", 32'(out_data), 32'({8'h10, core_fn(8'h10)}));
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("bp_unstall", 32'(busy), 32'd0);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    out_ready = 1;
    for (int i = 1; i < 5; i++) begin
      chk("bp_drain_valid", 32'(out_valid), 32'd1);
      chk("bp_drain_data", 32'(out_data), 32'({8'h10 + 8'(i), core_fn(8'h10 + 8'(i))}));
      tick;
    end
    chk("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 0;
    send(8'h21);
    send(8'h22);
    send(8'h23);
    chk("mid_settle_fifo", 32'(out_valid), 32'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_core_in", 32'(core_in), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick;
    rst_n = 1;
    tick;
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rel_empty", 32'(out_valid), 32'd0);
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      if (out_valid && out_ready) begin
        chk("rnd_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("rnd_data", 32'(out_data), 32'(q.pop_front()));
      end
      if (in_valid && in_ready) q.push_back({in_data, core_fn(in_data)});
      tick;
    end
    in_valid = 0;
    out_ready = 1;
    for (int c = 0; c < 100 && (q.size() != 0 || busy); c++) begin
      if (out_valid) begin
        chk("rnd_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("rnd_data", 32'(out_data), 32'(q.pop_front()));
      end
      tick;
    end
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_empty", 32'(out_valid), 32'd0);
    run_sweep(sig_a);
    run_sweep(sig_b);
    chk("sweep_repeat_sig", 32'(sig_b), 32'(sig_a));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
